gpio_walking_one_gen: RTL



---
 rtl/gpio_walking_one_gen_pkg.sv | 39 +++
 rtl/gpio_walking_one_gen_if.sv | 42 ++++
 rtl/gpio_walking_one_gen_dwell_timer.sv | 61 ++++++
 rtl/gpio_walking_one_gen.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/gpio_walking_one_gen_pkg.sv
// -----------------------------------------------------------------------------
// gpio_walking_one_pkg
// Shared definitions for the GPIO walking-one pattern source.
//   - run-state enumeration used by the top-level FSM
//   - default widths for the pin bank, dwell counter and pass counter
//   - pad mapping: pattern bit 0 drives mprj_io[0], bit k (k>=1) drives
//     mprj_io[k+4]; pad_io_index() gives the pad number for a pattern bit
// -----------------------------------------------------------------------------
package gpio_walking_one_pkg;

   localparam int WIDTH_DEFAULT   = 34;
   localparam int DWELL_W_DEFAULT = 24;
   localparam int ITER_W_DEFAULT  = 8;

   // Bit-index counter width; must cover WIDTH-1.
   localparam int IDX_W = 6;

   // Pad mapping: bit 0 -> io 0, bit k -> io k+4.
   localparam int PAD_IO_BIT0   = 0;
   localparam int PAD_IO_OFFSET = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ZERO_PRE  = 3'd1,
      ST_WALK      = 3'd2,
      ST_ZERO_POST = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

   // Pad number (mprj_io index) driven by a given pattern bit.
   function automatic int pad_io_index(input int bit_idx);
      if (bit_idx == 0) begin
         return PAD_IO_BIT0;
      end else begin
         return bit_idx + PAD_IO_OFFSET;
      end
   endfunction

endpackage

// File: rtl/gpio_walking_one_gen_if.sv
// -----------------------------------------------------------------------------
// gpio_walking_one_gen_if
// Control/pattern bundle for the walking-one generator.
//   master: drives start, en, dwell, num_iter; observes the pattern outputs
//   slave : the generator itself
// Signals:
//   start    - one-cycle launch pulse (honoured only from IDLE/DONE)
//   en       - 1 = advance, 0 = freeze
//   dwell    - cycles per frame minus one (latched on accepted start)
//   num_iter - pass count, 0 = run forever (latched on accepted start)
//   gpio_out - pattern to pads, gpio_oeb - active-low output enables
//   busy     - run in progress, done - finite run complete, step - frame strobe
// -----------------------------------------------------------------------------
interface gpio_walking_one_gen_if
   import gpio_walking_one_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int DWELL_W = DWELL_W_DEFAULT,
   parameter int ITER_W  = ITER_W_DEFAULT
);

   logic               start;
   logic               en;
   logic [DWELL_W-1:0] dwell;
   logic [ITER_W-1:0]  num_iter;
   logic [WIDTH-1:0]   gpio_out;
   logic [WIDTH-1:0]   gpio_oeb;
   logic               busy;
   logic               done;
   logic               step;

   modport master (
      output start, en, dwell, num_iter,
      input  gpio_out, gpio_oeb, busy, done, step
   );

   modport slave (
      input  start, en, dwell, num_iter,
      output gpio_out, gpio_oeb, busy, done, step
   );

endinterface

// File: rtl/gpio_walking_one_gen_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Loadable down-counter that times one frame of the walking-one sequence.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - capture load_val as both current count and reload value
//   load_val  - frame length minus one
//   run       - a run is in progress (counting allowed)
//   en        - advance enable; cycles with en=0 are not counted
//   expire    - high in the last enabled cycle of a frame; the counter
//               reloads on the same edge so frames repeat back to back
// -----------------------------------------------------------------------------
module dwell_timer #(
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   input  logic               run,
   input  logic               en,
   output logic               expire
);

   logic [DWELL_W-1:0] cnt_q,    cnt_d;
   logic [DWELL_W-1:0] reload_q, reload_d;
   logic               count_en;

   assign count_en = run & en;
   assign expire   = count_en & (cnt_q == {DWELL_W{1'b0}});

   // Next count: load, reload on expiry, or decrement while enabled.
   always_comb begin
      cnt_d    = cnt_q;
      reload_d = reload_q;
      if (load) begin
         cnt_d    = load_val;
         reload_d = load_val;
      end else if (count_en) begin
         if (cnt_q == {DWELL_W{1'b0}}) begin
            cnt_d = reload_q;
         end else begin
            cnt_d = cnt_q - {{(DWELL_W-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter and reload registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= {DWELL_W{1'b0}};
         reload_q <= {DWELL_W{1'b0}};
      end else begin
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
      end
   end

endmodule

// File: rtl/gpio_walking_one_gen.sv
// -----------------------------------------------------------------------------
// gpio_walking_one_gen
// Walking-one pattern source for the user-project GPIO bank. A run is one
// all-zero frame followed by num_iter passes of (WIDTH one-hot frames, one
// all-zero frame); num_iter=0 repeats forever. Each frame lasts dwell+1
// enabled cycles. All outputs are registered.
// Ports:
//   clk  - user clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of gpio_walking_one_gen_if (controls and pattern outputs)
// -----------------------------------------------------------------------------
module gpio_walking_one_gen
   import gpio_walking_one_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int DWELL_W = DWELL_W_DEFAULT,
   parameter int ITER_W  = ITER_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   gpio_walking_one_gen_if.slave bus
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e              state_q,    state_d;
   logic [IDX_W-1:0]    idx_q,      idx_d;
   logic [ITER_W-1:0]   pass_q,     pass_d;
   logic [ITER_W-1:0]   num_iter_q, num_iter_d;
   logic [WIDTH-1:0]    gpio_out_q, gpio_out_d;
   logic [WIDTH-1:0]    gpio_oeb_q, gpio_oeb_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;
   logic                step_q,     step_d;
   logic                start_acc;
   logic                expire;

   // start is ignored while a run is in progress
   assign start_acc = bus.start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

   // busy_q is high exactly in the running states, so it gates the timer.
   dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (start_acc),
      .load_val (bus.dwell),
      .run      (busy_q),
      .en       (bus.en),
      .expire   (expire)
   );

   // Frame sequencing: state, bit index, pass counter, frame strobe.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      pass_d     = pass_q;
      num_iter_d = num_iter_q;
      step_d     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_acc) begin
               state_d    = ST_ZERO_PRE;
               idx_d      = {IDX_W{1'b0}};
               pass_d     = {ITER_W{1'b0}};
               num_iter_d = bus.num_iter;
            end else begin
               state_d = state_q;
            end
         end
         ST_ZERO_PRE: begin
            if (expire) begin
               state_d = ST_WALK;
               idx_d   = {IDX_W{1'b0}};
               step_d  = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_WALK: begin
            if (expire) begin
               step_d = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = ST_ZERO_POST;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_ZERO_POST: begin
            if (expire) begin
               // In forever mode the pass counter simply wraps.
               pass_d = pass_q + ITER_W'(1);
               if ((num_iter_q != {ITER_W{1'b0}}) && (pass_d == num_iter_q)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WALK;
                  idx_d   = {IDX_W{1'b0}};
                  step_d  = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so the pins change with the state.
   always_comb begin
      gpio_out_d = {WIDTH{1'b0}};
      gpio_oeb_d = {WIDTH{1'b0}};
      busy_d     = 1'b0;
      done_d     = 1'b0;
      case (state_d)
         ST_IDLE: begin
            gpio_oeb_d = {WIDTH{1'b1}};
         end
         ST_ZERO_PRE, ST_ZERO_POST: begin
            busy_d = 1'b1;
         end
         ST_WALK: begin
            busy_d     = 1'b1;
            gpio_out_d = ONE_HOT0 << idx_d;
         end
         ST_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            gpio_oeb_d = {WIDTH{1'b1}};
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= {IDX_W{1'b0}};
         pass_q     <= {ITER_W{1'b0}};
         num_iter_q <= {ITER_W{1'b0}};
         gpio_out_q <= {WIDTH{1'b0}};
         gpio_oeb_q <= {WIDTH{1'b1}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         step_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pass_q     <= pass_d;
         num_iter_q <= num_iter_d;
         gpio_out_q <= gpio_out_d;
         gpio_oeb_q <= gpio_oeb_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         step_q     <= step_d;
      end
   end

   assign bus.gpio_out = gpio_out_q;
   assign bus.gpio_oeb = gpio_oeb_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.step     = step_q;

endmodule
